// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared types for the BTB / 2-bit counter predictor
package branch_predictor_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bpred_ctr_t;
  typedef enum logic [1:0] {NONE = 2'b00, BRANCH = 2'b01, JUMP = 2'b10, JR = 2'b11} bpred_kind_t;
  typedef struct packed {
    logic       valid;
    logic [29:0] tag;
    logic [31:0] target;
    bpred_ctr_t ctr;
  } btb_entry_t;
endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// sat_ctr2: 2-bit saturating up/down counter next-state
import branch_predictor_pkg::*;
module sat_ctr2 (
  input  bpred_ctr_t ctr,
  input  logic       up,
  output bpred_ctr_t nxt
);
  assign nxt = up ? (ctr == ST ? ST : bpred_ctr_t'(ctr + 2'd1))
                  : (ctr == SNT ? SNT : bpred_ctr_t'(ctr - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB + 2-bit counters, looked up in IF, trained from EX/MEM.
// Optional BPRED_STATS_EN adds saturating branch / mispredict counters.
import branch_predictor_pkg::*;
module branch_predictor #(
  parameter int         ENTRIES   = 16,
  parameter int         TAG_W     = 30 - $clog2(ENTRIES),
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_kind,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [31:0] upd_pred_npc,
  input  logic        clr,
  output logic        mispredict,
  output logic [31:0] correct_npc
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  btb_entry_t tbl [ENTRIES];
  logic [IDX_W-1:0] if_idx, u_idx;
  logic [TAG_W-1:0] if_tag, u_tag;
  btb_entry_t rd, u_rd, wdata;
  bpred_kind_t kind;
  bpred_ctr_t ctr_nxt;
  logic hit, u_hit, taken, wen;
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign rd = tbl[if_idx];
  assign hit = rd.valid && rd.tag == 30'(if_tag);
  assign pred_taken = hit && rd.ctr[1];
  assign pred_npc = pred_taken ? rd.target : if_pc + 32'd4;
  assign kind = bpred_kind_t'(upd_kind);
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign u_rd = tbl[u_idx];
  assign u_hit = u_rd.valid && u_rd.tag == 30'(u_tag);
  assign taken = kind == BRANCH ? upd_taken : kind != NONE;
  assign correct_npc = taken ? upd_target : upd_pc + 32'd4;
  assign mispredict = upd_valid && kind != NONE && correct_npc != upd_pred_npc;
  sat_ctr2 u_ctr (.ctr(u_rd.ctr), .up(upd_taken), .nxt(ctr_nxt));
  always_comb begin
    wdata = u_rd;
    wen = 1'b0;
    if (kind == BRANCH && u_hit) begin
      wdata.ctr = ctr_nxt;
      wdata.target = upd_taken ? upd_target : u_rd.target;
      wen = 1'b1;
    end else if ((kind == BRANCH && upd_taken) || kind == JUMP) begin
      wdata = '{valid: 1'b1, tag: 30'(u_tag), target: upd_target,
                ctr: kind == JUMP ? ST : bpred_ctr_t'(CTR_ALLOC)};
      wen = 1'b1;
    end else if (kind == JR && u_hit) begin
      wdata.valid = 1'b0;
      wen = 1'b1;
    end
  end
  // clr beats a concurrent update; the update is simply dropped
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (upd_valid && wen) begin
      tbl[u_idx] <= wdata;
    end
  end
`ifdef BPRED_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches <= '0;
      stat_mispred <= '0;
    end else begin
      if (upd_valid && kind != NONE && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed-vector bench for branch_predictor (optionally with BPRED_STATS_EN)
module tb_branch_predictor;
  logic        CLK = 0;
  logic        nRST = 0;
  logic [31:0] if_pc = 0;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_valid = 0;
  logic [31:0] upd_pc = 0;
  logic [1:0]  upd_kind = 0;
  logic        upd_taken = 0;
  logic [31:0] upd_target = 0;
  logic [31:0] upd_pred_npc = 0;
  logic        clr = 0;
  logic        mispredict;
  logic [31:0] correct_npc;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches, stat_mispred;
`endif
  int vecs = 0;
  int errs = 0;

  branch_predictor dut (
    .CLK(CLK), .nRST(nRST), .if_pc(if_pc), .pred_taken(pred_taken), .pred_npc(pred_npc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_npc(upd_pred_npc), .clr(clr),
    .mispredict(mispredict), .correct_npc(correct_npc)
`ifdef BPRED_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] k, input logic t,
                     input logic [31:0] tgt, input logic [31:0] pn);
    upd_valid = 1; upd_pc = pc; upd_kind = k; upd_taken = t; upd_target = tgt; upd_pred_npc = pn;
    #1;
  endtask

  task automatic idle();
    upd_valid = 0; upd_kind = 0; clr = 0;
    #1;
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic [31:0] exp);
    if_pc = pc;
    #1;
    vecs++;
    if (pred_npc !== exp) begin
      errs++;
      $display("FAIL %s: pred_npc got %h expected %h", name, pred_npc, exp);
    end
  endtask

  task automatic chk_upd(input string name, input logic exp_mp, input logic [31:0] exp_npc);
    vecs++;
    if (mispredict !== exp_mp || correct_npc !== exp_npc) begin
      errs++;
      $display("FAIL %s: mispredict/correct_npc got %b/%h expected %b/%h",
               name, mispredict, correct_npc, exp_mp, exp_npc);
    end
  endtask

  task automatic do_reset();
    idle();
    nRST = 0;
    #3;
    nRST = 1;
    tick();
  endtask

  task automatic test_reset();
    nRST = 0;
    if_pc = 32'h40;
    #2;
    vecs++;
    if (pred_taken !== 1'b0 || pred_npc !== 32'h44 || mispredict !== 1'b0) begin
      errs++;
      $display("FAIL reset: taken/npc/mp got %b/%h/%b expected 0/00000044/0", pred_taken, pred_npc, mispredict);
    end
    nRST = 1;
    tick();
  endtask

  task automatic test_alloc();
    upd(32'h40, 2'b01, 1, 32'h80, 32'h44);
    chk_upd("alloc_mp", 1, 32'h80);
    chk_pred("alloc_same_cycle", 32'h40, 32'h44);
    tick();
    idle();
    chk_pred("alloc_next", 32'h40, 32'h80);
  endtask

  task automatic test_counter();
    upd(32'h40, 2'b01, 0, 32'h80, 32'h80);
    chk_upd("nt1_mp", 1, 32'h44);
    tick(); idle();
    chk_pred("ctr_01", 32'h40, 32'h44);
    upd(32'h40, 2'b01, 0, 32'h80, 32'h44);
    chk_upd("nt2_mp", 0, 32'h44);
    tick(); idle();
    chk_pred("ctr_00", 32'h40, 32'h44);
    upd(32'h40, 2'b01, 0, 32'h80, 32'h44);
    tick(); idle();
    upd(32'h40, 2'b01, 1, 32'h80, 32'h44);
    tick(); idle();
    chk_pred("floor_held", 32'h40, 32'h44);
    upd(32'h40, 2'b01, 1, 32'h90, 32'h44);
    tick(); idle();
    chk_pred("retrain_target", 32'h40, 32'h90);
  endtask

  task automatic test_jump_replace();
    upd(32'h40, 2'b10, 0, 32'h1000, 32'h44);
    chk_upd("jal_mp", 1, 32'h1000);
    tick(); idle();
    chk_pred("jal_pred", 32'h40, 32'h1000);
    upd(32'h80, 2'b10, 0, 32'h2000, 32'h84);
    tick(); idle();
    chk_pred("victim_gone", 32'h40, 32'h44);
    chk_pred("j_pred", 32'h80, 32'h2000);
    upd(32'h80, 2'b01, 0, 32'h2000, 32'h2000);
    tick(); idle();
    chk_pred("jump_ctr_11", 32'h80, 32'h2000);
    upd(32'h0C, 2'b01, 0, 32'h500, 32'h10);
    tick(); idle();
    chk_pred("nt_no_alloc", 32'h0C, 32'h10);
  endtask

  task automatic test_clr();
    clr = 1;
    upd(32'h100, 2'b01, 1, 32'h180, 32'h104);
    chk_upd("clr_mp", 1, 32'h180);
    tick(); idle();
    chk_pred("clr_no_alloc", 32'h100, 32'h104);
    chk_pred("clr_invalidated", 32'h80, 32'h84);
  endtask

  task automatic test_jr();
    do_reset();
    upd(32'h200, 2'b11, 0, 32'h300, 32'h204);
    chk_upd("jr_mp", 1, 32'h300);
    tick(); idle();
    chk_pred("jr_no_alloc", 32'h200, 32'h204);
`ifdef BPRED_STATS_EN
    vecs++;
    if (stat_branches !== 32'd1 || stat_mispred !== 32'd1) begin
      errs++;
      $display("FAIL stats: got %0d/%0d expected 1/1", stat_branches, stat_mispred);
    end
`endif
    upd(32'h200, 2'b10, 0, 32'h400, 32'h204);
    tick(); idle();
    chk_pred("jal_before_jr", 32'h200, 32'h400);
    upd(32'h200, 2'b11, 0, 32'h400, 32'h400);
    chk_upd("jr_hit_mp", 0, 32'h400);
    tick(); idle();
    chk_pred("jr_invalidate", 32'h200, 32'h204);
  endtask

  task automatic test_wrap_and_none();
    chk_pred("wrap_pc", 32'hFFFFFFFC, 32'h0);
    upd(32'hFFFFFFFC, 2'b01, 0, 32'h10, 32'h0);
    chk_upd("wrap_upd", 0, 32'h0);
    upd(32'h40, 2'b00, 1, 32'h800, 32'h44);
    vecs++;
    if (mispredict !== 1'b0) begin
      errs++;
      $display("FAIL kind_none: mispredict got %b expected 0", mispredict);
    end
    tick(); idle();
    chk_pred("none_no_alloc", 32'h40, 32'h44);
  endtask

  task automatic test_async_reset();
    upd(32'h40, 2'b10, 0, 32'h600, 32'h44);
    tick(); idle();
    chk_pred("pre_async", 32'h40, 32'h600);
    #2 nRST = 0;
    #1;
    vecs++;
    if (pred_taken !== 1'b0 || pred_npc !== 32'h44) begin
      errs++;
      $display("FAIL async_reset: taken/npc got %b/%h expected 0/00000044", pred_taken, pred_npc);
    end
    nRST = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_jump_replace();
    test_clr();
    test_jr();
    test_wrap_and_none();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
